// File: rtl/regfile_onehot.sv
// Register file written through a one-hot select, read through two registered binary-address ports.
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_onehot #(
  parameter int n        = 5,
  parameter int m        = 32,
  parameter int w        = 32,
  parameter int zero_reg = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [m-1:0] wr_sel,
  input  logic [w-1:0] wr_data,
  input  logic [n-1:0] rd_addr_a,
  output logic [w-1:0] rd_data_a,
  input  logic [n-1:0] rd_addr_b,
  output logic [w-1:0] rd_data_b,
  output logic         sel_err
);

  if (m != (1 << n)) begin : g_bad_geometry
    $error("regfile_onehot: m (%0d) must equal 2**n (n=%0d)", m, n);
  end

  // A select is legal only if it is non-zero and clearing its lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [m-1:0] v);
    logic [m-1:0] low_cleared;
    low_cleared = v & (v - {{(m-1){1'b0}}, 1'b1});
    return (v != {m{1'b0}}) && (low_cleared == {m{1'b0}});
  endfunction

  logic [w-1:0] regs [m];
  logic         sel_ok;
  logic         wr_valid;
  logic         wr_bad;
  logic [m-1:0] wr_mask;
  logic [w-1:0] rd_next_a;
  logic [w-1:0] rd_next_b;

  // Qualify the select; wr_mask holds the single register that will actually change this edge.
  always_comb begin
    sel_ok   = is_onehot(wr_sel);
    wr_valid = wr_en & sel_ok;
    wr_bad   = wr_en & ~sel_ok;
    wr_mask  = {m{1'b0}};
    if (wr_valid) begin
      wr_mask = wr_sel;
    end else begin
      wr_mask = {m{1'b0}};
    end
    if (zero_reg != 0) begin
      wr_mask[0] = 1'b0;
    end else begin
      wr_mask[0] = wr_mask[0];
    end
  end

  // Register array update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < m; i++) begin
        regs[i] <= {w{1'b0}};
      end
    end else begin
      for (int i = 0; i < m; i++) begin
        if (wr_mask[i]) begin
          regs[i] <= wr_data;
        end else begin
          regs[i] <= regs[i];
        end
      end
    end
  end

  // Next read data for both ports; wr_mask already excludes dropped and zero-register writes.
  always_comb begin
    rd_next_a = regs[rd_addr_a];
    rd_next_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_mask[rd_addr_a]) begin
      rd_next_a = wr_data;
    end else begin
      rd_next_a = regs[rd_addr_a];
    end
    if (wr_mask[rd_addr_b]) begin
      rd_next_b = wr_data;
    end else begin
      rd_next_b = regs[rd_addr_b];
    end
`endif
    if ((zero_reg != 0) && (rd_addr_a == {n{1'b0}})) begin
      rd_next_a = {w{1'b0}};
    end else begin
      rd_next_a = rd_next_a;
    end
    if ((zero_reg != 0) && (rd_addr_b == {n{1'b0}})) begin
      rd_next_b = {w{1'b0}};
    end else begin
      rd_next_b = rd_next_b;
    end
  end

  // Registered read ports and the sticky select-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= {w{1'b0}};
      rd_data_b <= {w{1'b0}};
      sel_err   <= 1'b0;
    end else begin
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
      if (wr_bad) begin
        sel_err <= 1'b1;
      end else begin
        sel_err <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Directed scoreboard bench for regfile_onehot: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_onehot;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        sel_err;

  regfile_onehot #(.n(5), .m(32), .w(32), .zero_reg(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: outputs are stable between edges, so compare at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due != cyc) begin
        n_checks++; n_fail++;
        $display("FAIL %s: expectation missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
      end else begin
        n_checks++;
        if (rd_data_a !== e.exp_a) begin
          n_fail++;
          $display("FAIL %s rd_data_a: got %h expected %h", e.name, rd_data_a, e.exp_a);
        end
        n_checks++;
        if (rd_data_b !== e.exp_b) begin
          n_fail++;
          $display("FAIL %s rd_data_b: got %h expected %h", e.name, rd_data_b, e.exp_b);
        end
        n_checks++;
        if (sel_err !== e.exp_err) begin
          n_fail++;
          $display("FAIL %s sel_err: got %b expected %b", e.name, sel_err, e.exp_err);
        end
      end
    end
  end

  // One clock of stimulus; when chk is set, the result of this edge is queued for checking.
  task automatic step(input logic r, input logic we, input logic [31:0] sel, input logic [31:0] d,
                      input logic [4:0] aa, input logic [4:0] ab, input logic chk,
                      input logic [31:0] ea, input logic [31:0] eb, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_sel = sel; wr_data = d; rd_addr_a = aa; rd_addr_b = ab;
    if (chk) begin
      e.due = cyc + 1; e.exp_a = ea; e.exp_b = eb; e.exp_err = ee; e.name = nm;
      q.push_back(e);
    end
  endtask

  task automatic wr(input logic [31:0] sel, input logic [31:0] d);
    step(1'b0, 1'b1, sel, d, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, "");
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, "");
  endtask

  logic [31:0] coll_exp;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 32'h0; wr_data = 32'h0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd31, 1'b1, 32'h0, 32'h0, 1'b0, "reset_state");

    // 1: reset wipes a written register
    wr(32'h0000_0080, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "pre_reset_r7");
    do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0, "post_reset_r7");

    // rst beats a simultaneous write
    step(1'b1, 1'b1, 32'h0000_0040, 32'h6666_6666, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, "");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd6, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0, "rst_beats_write");

    // 2: two writes, both ports
    wr(32'h0000_0020, 32'h1234_5678);
    wr(32'h8000_0000, 32'hCAFE_F00D);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd31, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, "rd_5_31");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd5, 1'b1, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, "rd_31_5");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, "rd_same_reg");

    // 3: zero register ignores writes, including the bypass path
    wr(32'h0000_0001, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, "zero_reg");
    step(1'b0, 1'b1, 32'h0000_0001, 32'h0000_00FF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, "zero_reg_coll");

    // 4: two-bit select dropped, error sticky until reset
    wr(32'h0000_0008, 32'hAAAA_AAAA);
    step(1'b0, 1'b1, 32'h0000_0009, 32'h5555_5555, 5'd3, 5'd0, 1'b1, 32'hAAAA_AAAA, 32'h0, 1'b1, "bad2_cycle");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b1, 32'hAAAA_AAAA, 32'h0, 1'b1, "bad2_after");
    wr(32'h0000_0010, 32'h0000_0044);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd3, 1'b1, 32'h0000_0044, 32'hAAAA_AAAA, 1'b1, "err_sticky");
    do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd4, 1'b1, 32'h0, 32'h0, 1'b0, "err_cleared");

    // 5: zero-bit select flags; wr_en=0 never flags or writes
    wr(32'h0000_0004, 32'h0000_0022);
    step(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0099, 5'd2, 5'd0, 1'b1, 32'h0000_0022, 32'h0, 1'b1, "bad0");
    do_reset();
    step(1'b0, 1'b0, 32'h0000_0003, 32'h0000_0033, 5'd1, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, "no_en_sel3");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, "no_en_no_write");

    // 6: same-edge read/write collision
`ifdef REGFILE_BYPASS_EN
    coll_exp = 32'h0000_0002;
`else
    coll_exp = 32'h0000_0001;
`endif
    wr(32'h0000_0200, 32'h0000_0001);
    step(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0002, 5'd9, 5'd9, 1'b1, coll_exp, coll_exp, 1'b0, "collision");
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 32'h0000_0002, 32'h0, 1'b0, "after_collision");

    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_onehot.md
Name: regfile_onehot

Overview:
- Register file that sits directly downstream of the write-address one-hot decoder.
- Takes the decoder's m-bit one-hot word as the write select, plus two binary read addresses, and provides two registered read ports.
- Guards against malformed select words: writes with a non-one-hot select are dropped and flagged with a sticky error.

Parameters:
- n, 5: read address width in bits.
- m, 32: number of registers. Must equal 2^n.
- w, 32: data width in bits.
- zero_reg, 1: when 1, register 0 always reads 0 and ignores writes. When 0, register 0 is an ordinary register.

Ports:
- clk  input  1: clock. All state updates on the rising edge.
- rst  input  1: synchronous reset, active-high.
- wr_en  input  1: write request this cycle.
- wr_sel  input  m: one-hot write select, from the decoder.
- wr_data  input  w: write data.
- rd_addr_a  input  n: read address, port A.
- rd_data_a  output  w: registered read data, port A.
- rd_addr_b  input  n: read address, port B.
- rd_data_b  output  w: registered read data, port B.
- sel_err  output  1: sticky flag; set when a write request carries a non-one-hot select.

Behaviour:
- Reset:
  - One clock, clk.
  - rst is sampled on the rising edge of clk; it is synchronous and active-high.
  - While rst=1 at an edge: all m registers clear to 0, rd_data_a and rd_data_b clear to 0, and sel_err clears to 0.
  - rst has priority over writes in the same cycle. A write presented alongside rst is lost.
  - rst asserted mid-stream discards all contents. The first read after rst deasserts returns 0.
- Write validity:
  - A write is valid when wr_en=1 and wr_sel has exactly one bit set.
  - A valid write to index k updates reg[k] with wr_data at the edge. Exception: k=0 with zero_reg=1 is silently ignored and is not an error.
- Select errors:
  - wr_en=1 with wr_sel=0, or with two or more bits set, is a select error.
  - On a select error no register changes, and sel_err is set at that edge.
  - sel_err stays set until rst.
  - wr_en=0 never writes and never flags an error, whatever the value of wr_sel.
- Reads:
  - Each port has 1-cycle latency: rd_data_x at edge t+1 reflects rd_addr_x sampled at edge t.
  - Both ports are fully independent. Both may address the same register.
  - With zero_reg=1, reading address 0 returns 0.
- Same-cycle read/write collision (read address equals the index of a valid write at the same edge):
  - Default (bypass compiled out): the read returns the pre-write value; the new value is visible from the next read.
  - See Optional Feature for the bypass behaviour.
- Widths: no arithmetic. rd_addr spans 0..m-1 exactly, so there is no out-of-range case.
- Parameter check: if m != 2^n, the block emits a $error at elaboration.
- No state machine: the state is the register array, the two output registers and the sticky flag.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: on a valid write to index k at edge t, any read port sampling address k at edge t outputs wr_data at t+1 (write-first).
  - The bypass is suppressed for k=0 when zero_reg=1; the output stays 0.
  - The bypass is suppressed on select errors.
- Undefined: read-first behaviour as described in Behaviour.
- Register contents after the write are identical either way.

Test Plan:
1. Reset clears everything: write 32'hDEADBEEF to reg 7, assert rst for one cycle, then read reg 7 on port A -> rd_data_a = 0 and sel_err = 0.
2. Write then read on both ports:
   - Writes: wr_sel=32'h0000_0020 with data 32'h1234_5678, then wr_sel=32'h8000_0000 with data 32'hCAFE_F00D.
   - Reads: rd_addr_a=5, rd_addr_b=31.
   - Required: one cycle after the reads, rd_data_a=32'h1234_5678 and rd_data_b=32'hCAFE_F00D.
3. Zero register (zero_reg=1): write 32'hFFFF_FFFF with wr_sel=32'h1, then read address 0 -> returns 0 and sel_err stays 0.
4. Bad select, two bits:
   - Preload reg 3 = 32'hAAAA_AAAA.
   - Write 32'h5555_5555 with wr_sel=32'h0000_0009 -> reg 0 and reg 3 unchanged (reg 3 reads 32'hAAAA_AAAA); sel_err=1 from the next cycle.
   - sel_err stays 1 through a following valid write and clears only on rst.
5. Bad select, zero bits: wr_en=1 with wr_sel=0 -> sel_err=1 and no register changes. wr_en=0 with wr_sel=32'h0000_0003 -> no flag.
6. Collision: reg 9 = 32'h1, then in the same cycle write 32'h2 to reg 9 and read rd_addr_a=9.
   - Without REGFILE_BYPASS_EN: rd_data_a=32'h1.
   - With REGFILE_BYPASS_EN: rd_data_a=32'h2.
   - Either way the next read of reg 9 returns 32'h2.
